// File: rtl/ysyx_25040111_ifu.sv
// ysyx_25040111_ifu: instruction fetch unit.
// Owns the PC. Issues one 32-bit read at a time to instruction memory and
// hands each fetched word with its PC to decode over valid/ready. Redirects
// from execute replace the PC; any fetch already in flight is discarded.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_req_valid/ready/addr        instruction memory read request
//   imem_rsp_valid/data/err          instruction memory read response
//   inst_valid/ready, inst,
//   inst_pc, inst_fault              instruction handed to decode
//   redirect_valid, redirect_pc      new PC from execute
//
// Build option:
//   IFU_MISALIGN_CHK_EN  when defined, a redirect to a non-word-aligned
//                        target issues no fetch and presents a faulting
//                        instruction (inst=0, inst_fault=1) instead. When
//                        undefined, the low two target bits are cleared.
module ysyx_25040111_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [XLEN-1:0]   pc_q, pc_nxt;
    logic              kill_q, kill_nxt;
    // A misaligned redirect is waiting for the in-flight response to drain.
    logic              mis_q, mis_nxt;
    logic              req_valid_q, req_valid_nxt;
    logic [XLEN-1:0]   req_addr_q, req_addr_nxt;
    logic              inst_valid_q, inst_valid_nxt;
    logic [XLEN-1:0]   inst_q, inst_nxt;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_nxt;
    logic              inst_fault_q, inst_fault_nxt;

    logic [XLEN-1:0]   target_c;
    logic              target_bad_c;
    logic              load_fault_c;

    // Redirect target as loaded into pc, and whether it must fault.
`ifdef IFU_MISALIGN_CHK_EN
    assign target_c     = redirect_pc;
    assign target_bad_c = (redirect_pc[1:0] != 2'b00);
`else
    assign target_c     = redirect_pc & ~XLEN'(3);
    assign target_bad_c = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            mis_q        <= 1'b0;
            req_valid_q  <= 1'b1;
            req_addr_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            kill_q       <= kill_nxt;
            mis_q        <= mis_nxt;
            req_valid_q  <= req_valid_nxt;
            req_addr_q   <= req_addr_nxt;
            inst_valid_q <= inst_valid_nxt;
            inst_q       <= inst_nxt;
            inst_pc_q    <= inst_pc_nxt;
            inst_fault_q <= inst_fault_nxt;
        end
    end

    // Next-state, PC and instruction-buffer logic.
    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_q;
        kill_nxt       = kill_q;
        mis_nxt        = mis_q;
        inst_nxt       = inst_q;
        inst_pc_nxt    = inst_pc_q;
        inst_fault_nxt = inst_fault_q;
        load_fault_c   = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nxt = target_c;
                    if (target_bad_c) begin
                        if (imem_req_ready) begin
                            // Request already taken: drain its response first.
                            kill_nxt  = 1'b1;
                            mis_nxt   = 1'b1;
                            state_nxt = S_WAIT;
                        end else begin
                            kill_nxt     = 1'b0;
                            load_fault_c = 1'b1;
                            state_nxt    = S_HOLD;
                        end
                    end else begin
                        // Old request stays presented; its response is dropped.
                        kill_nxt = 1'b1;
                        mis_nxt  = 1'b0;
                        if (imem_req_ready) begin
                            state_nxt = S_WAIT;
                        end
                    end
                end else if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid || kill_q) begin
                        kill_nxt = 1'b0;
                        mis_nxt  = 1'b0;
                        if (redirect_valid) begin
                            pc_nxt = target_c;
                        end
                        if (redirect_valid ? target_bad_c : mis_q) begin
                            load_fault_c = 1'b1;
                            state_nxt    = S_HOLD;
                        end else begin
                            state_nxt = S_REQ;
                        end
                    end else begin
                        inst_nxt       = imem_rsp_err ? '0 : imem_rsp_data;
                        inst_pc_nxt    = pc_q;
                        inst_fault_nxt = imem_rsp_err;
                        state_nxt      = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_nxt   = target_c;
                    kill_nxt = 1'b1;
                    mis_nxt  = target_bad_c;
                end
            end

            S_HOLD: begin
                // Redirect wins over inst_ready: the held instruction is dropped.
                if (redirect_valid) begin
                    pc_nxt = target_c;
                    if (target_bad_c) begin
                        load_fault_c = 1'b1;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end else if (inst_ready) begin
                    pc_nxt    = pc_q + XLEN'(4);
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase

        if (load_fault_c) begin
            inst_nxt       = '0;
            inst_pc_nxt    = pc_nxt;
            inst_fault_nxt = 1'b1;
        end
    end

    // Registered request/valid outputs; an unaccepted request keeps its address.
    always_comb begin
        req_valid_nxt  = (state_nxt == S_REQ);
        inst_valid_nxt = (state_nxt == S_HOLD);
        req_addr_nxt   = pc_nxt;
        if ((state_q == S_REQ) && !imem_req_ready && (state_nxt == S_REQ)) begin
            req_addr_nxt = req_addr_q;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = inst_fault_q;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Testbench for ysyx_25040111_ifu: directed scenarios plus a randomized run
// checked against a path-level model (decode must see consecutive words of
// the current path, restarted at every redirect target).
module tb_ysyx_25040111_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_err   = 1'b0;
    logic        inst_valid;
    logic        inst_ready     = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model controls.
    int          lat       = 1;
    bit          lat_rand  = 1'b0;
    bit          rdy_rand  = 1'b0;
    bit          err_rand  = 1'b0;
    logic [31:0] err_addr  = 32'h1;
    int          hold_viol = 0;
    int          overlap_viol = 0;

    ysyx_25040111_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == err_addr) || (err_rand && (a[5:2] == 4'hB));
    endfunction

    // Instruction memory: one response per accepted request after a latency,
    // plus protocol monitors for address stability and single outstanding.
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          cd = 0;
    logic        prev_unacc = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    always begin
        @(posedge clk);
        if (!rst_n) begin
            pend       = 1'b0;
            prev_unacc = 1'b0;
        end else begin
            if (prev_unacc && (!imem_req_valid || imem_req_addr != prev_addr)) hold_viol++;
            prev_unacc = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            if (pend && imem_rsp_valid) pend = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                if (pend) overlap_viol++;
                pend  = 1'b1;
                paddr = imem_req_addr;
                cd    = lat_rand ? int'($urandom_range(1, 3)) : lat;
            end
        end
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
        if (pend) begin
            cd--;
            if (cd == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(paddr);
                imem_rsp_err   = mem_err(paddr);
            end
        end
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !inst_valid; i++) step();
    endtask

    task automatic test_reset();
        lat = 1;
        rst_n = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0)
            begin n_fail++; $display("FAIL reset_req: valid=%b addr=%h ivalid=%b, need 1 %h 0", imem_req_valid, imem_req_addr, inst_valid, RESET_PC); end
        n_tests++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0)
            begin n_fail++; $display("FAIL reset_buf: inst=%h pc=%h f=%b, need 0", inst, inst_pc, inst_fault); end
        rst_n = 1'b1;
        wait_valid(20);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== mem_word(RESET_PC))
            begin n_fail++; $display("FAIL reset_first: v=%b pc=%h inst=%h, need 1 %h %h", inst_valid, inst_pc, inst, RESET_PC, mem_word(RESET_PC)); end
        // Reset again while the next fetch is outstanding.
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_tests++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_valid !== 1'b0 || imem_req_addr !== RESET_PC || imem_req_valid !== 1'b1)
            begin n_fail++; $display("FAIL reset_mid: inst=%h pc=%h v=%b addr=%h rv=%b", inst, inst_pc, inst_valid, imem_req_addr, imem_req_valid); end
        rst_n = 1'b1;
        wait_valid(20);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC)
            begin n_fail++; $display("FAIL reset_mid_refetch: v=%b pc=%h, need 1 %h", inst_valid, inst_pc, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        lat = 1;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            exp_pc = RESET_PC + 32'(4 * (c / 3));
            n_tests++;
            if (imem_req_valid !== (c % 3 == 0) || inst_valid !== (c % 3 == 2))
                begin n_fail++; $display("FAIL seq_phase c=%0d: rv=%b iv=%b", c, imem_req_valid, inst_valid); end
            if (c % 3 == 0) begin
                n_tests++;
                if (imem_req_addr !== exp_pc)
                    begin n_fail++; $display("FAIL seq_addr c=%0d: %h, need %h", c, imem_req_addr, exp_pc); end
            end
            if (c % 3 == 2) begin
                n_tests++;
                if (inst_pc !== exp_pc || inst !== mem_word(exp_pc) || inst_fault !== 1'b0)
                    begin n_fail++; $display("FAIL seq_inst c=%0d: pc=%h inst=%h, need %h %h", c, inst_pc, inst, exp_pc, mem_word(exp_pc)); end
            end
            step();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== mem_word(RESET_PC) || imem_req_valid !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold i=%0d: v=%b pc=%h inst=%h rv=%b", i, inst_valid, inst_pc, inst, imem_req_valid); end
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC + 32'd4 || inst_valid !== 1'b0)
            begin n_fail++; $display("FAIL stall_release: rv=%b addr=%h iv=%b, need 1 %h 0", imem_req_valid, imem_req_addr, inst_valid, RESET_PC + 32'd4); end
    endtask

    task automatic test_redirect_wait();
        lat = 4;
        do_reset();
        inst_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_1000;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0)
                begin n_fail++; $display("FAIL redir_wait_drain i=%0d: iv=%b rv=%b, need 0 0", i, inst_valid, imem_req_valid); end
            step();
        end
        lat = 1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000 || inst_valid !== 1'b0)
            begin n_fail++; $display("FAIL redir_wait_req: rv=%b addr=%h iv=%b, need 1 80001000 0", imem_req_valid, imem_req_addr, inst_valid); end
        wait_valid(20);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_1000 || inst !== mem_word(32'h8000_1000))
            begin n_fail++; $display("FAIL redir_wait_inst: v=%b pc=%h inst=%h", inst_valid, inst_pc, inst); end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        bit found = 1'b0;
        lat = 1;
        do_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            if (inst_valid && inst_pc == 32'h8000_0010) found = 1'b1;
            else begin inst_ready = 1'b1; step(); end
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL redir_hold_reach: pc 80000010 not presented, last %h", inst_pc); end
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100 || inst_valid !== 1'b0)
            begin n_fail++; $display("FAIL redir_hold_prio: rv=%b addr=%h iv=%b, need 1 80000100 0", imem_req_valid, imem_req_addr, inst_valid); end
        wait_valid(20);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100)
            begin n_fail++; $display("FAIL redir_hold_inst: v=%b pc=%h, need 1 80000100", inst_valid, inst_pc); end
        // PC wraps past the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wrap_req: rv=%b addr=%h, need 1 fffffffc", imem_req_valid, imem_req_addr); end
        wait_valid(20);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC))
            begin n_fail++; $display("FAIL wrap_inst: v=%b pc=%h inst=%h", inst_valid, inst_pc, inst); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            begin n_fail++; $display("FAIL wrap_next: rv=%b addr=%h, need 1 00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_fault();
        bit found = 1'b0;
        lat = 1;
        err_addr = 32'h8000_0020;
        do_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            if (inst_valid && inst_pc == 32'h8000_0020) found = 1'b1;
            else begin
                if (inst_valid && inst_pc == 32'h8000_001C) begin
                    n_tests++;
                    if (inst_fault !== 1'b0 || inst !== mem_word(32'h8000_001C))
                        begin n_fail++; $display("FAIL fault_clean: f=%b inst=%h", inst_fault, inst); end
                end
                inst_ready = 1'b1;
                step();
            end
        end
        inst_ready = 1'b0;
        n_tests++;
        if (!found || inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 1'b1)
            begin n_fail++; $display("FAIL fault_inst: found=%b v=%b inst=%h f=%b pc=%h, need inst 0 f 1", found, inst_valid, inst, inst_fault, inst_pc); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0024)
            begin n_fail++; $display("FAIL fault_next: rv=%b addr=%h, need 1 80000024", imem_req_valid, imem_req_addr); end
        err_addr = 32'h1;
    endtask

    task automatic test_misalign();
        lat = 1;
        do_reset();
        wait_valid(20);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h8000_0102 || inst_fault !== 1'b1 || inst !== 32'h0)
                begin n_fail++; $display("FAIL misalign_hold i=%0d: rv=%b iv=%b pc=%h f=%b inst=%h", i, imem_req_valid, inst_valid, inst_pc, inst_fault, inst); end
            step();
        end
        // Misaligned redirect while a fetch is outstanding.
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        lat = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0206;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
                begin n_fail++; $display("FAIL misalign_drain i=%0d: rv=%b iv=%b", i, imem_req_valid, inst_valid); end
            step();
        end
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0206 || inst_fault !== 1'b1 || inst !== 32'h0 || imem_req_valid !== 1'b0)
            begin n_fail++; $display("FAIL misalign_wait: iv=%b pc=%h f=%b inst=%h rv=%b", inst_valid, inst_pc, inst_fault, inst, imem_req_valid); end
`else
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100)
            begin n_fail++; $display("FAIL misalign_clear: rv=%b addr=%h, need 1 80000100", imem_req_valid, imem_req_addr); end
        wait_valid(20);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst_fault !== 1'b0)
            begin n_fail++; $display("FAIL misalign_inst: v=%b pc=%h f=%b", inst_valid, inst_pc, inst_fault); end
`endif
        lat = 1;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_f;
        bit          rdy;
        bit          redir;
        int          delivered = 0;
        rdy_rand = 1'b1;
        lat_rand = 1'b1;
        err_rand = 1'b1;
        do_reset();
        hold_viol = 0;
        overlap_viol = 0;
        exp_pc = RESET_PC;
        for (int c = 0; c < 3000; c++) begin
            if (inst_valid) begin
                exp_f    = mem_err(exp_pc);
                exp_inst = exp_f ? 32'h0 : mem_word(exp_pc);
                n_tests++;
                if (inst_pc !== exp_pc || inst !== exp_inst || inst_fault !== exp_f)
                    begin n_fail++; $display("FAIL rand_inst c=%0d: pc=%h inst=%h f=%b, need %h %h %b", c, inst_pc, inst, inst_fault, exp_pc, exp_inst, exp_f); end
            end
            n_tests++;
            if (inst_valid && imem_req_valid)
                begin n_fail++; $display("FAIL rand_req_in_hold c=%0d: rv=%b iv=%b", c, imem_req_valid, inst_valid); end
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 11) == 0);
            inst_ready     = rdy;
            redirect_valid = redir;
            redirect_pc    = {16'h8000, 14'($urandom), 2'b00};
            if (redir) exp_pc = redirect_pc;
            else if (inst_valid && rdy) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            step();
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        n_tests++;
        if (hold_viol !== 0 || overlap_viol !== 0)
            begin n_fail++; $display("FAIL rand_protocol: addr_changes=%0d overlaps=%0d, need 0 0", hold_viol, overlap_viol); end
        n_tests++;
        if (delivered < 100)
            begin n_fail++; $display("FAIL rand_progress: delivered=%0d, need >= 100", delivered); end
        rdy_rand = 1'b0;
        lat_rand = 1'b0;
        err_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_fault();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
